cmd_pack_queue: RTL and testbench

CMD_PACK_QUEUE -- requirements
Module: cmd_pack_queue

---
 rtl/cmd_pack_queue_pkg.sv | 15 +
 rtl/cmd_pack_queue_pack_fifo.sv | 70 +++++++
 rtl/cmd_pack_queue.sv | 136 +++++++++++++
 tb/tb_cmd_pack_queue.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_pack_queue_pkg.sv
// Shared defines for the command dispatcher and its packet queue:
// FSM state encoding, command width and default sizing.
package cmd_pack_queue_pkg;

    localparam int CMD_W       = 8;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 1023;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } disp_state_t;

endpackage

// File: rtl/cmd_pack_queue_pack_fifo.sv
// pack_fifo: circular packet store with a separate occupancy counter so
// full and empty are never ambiguous. Flush clears pointers and level.
module pack_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 40
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   wdata,
    output logic [WIDTH-1:0]   rdata,
    output logic [$clog2(DEPTH):0] level,
    output logic               full,
    output logic               empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    level_q, level_d;
    logic              do_push, do_pop;

    // A push at full is only legal when the head leaves in the same cycle.
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    assign rdata = mem_q[rd_ptr_q];
    assign level = level_q;
    assign full  = (level_q == (PTR_W+1)'(DEPTH));
    assign empty = (level_q == '0);

    // Pointer and occupancy next-state; pointers wrap naturally (DEPTH is 2^n).
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      level_d = level_q + 1'b1;
            else if (do_pop && !do_push) level_d = level_q - 1'b1;
        end
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Packet storage; contents are only meaningful below the level count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/cmd_pack_queue.sv
// cmd_pack_queue: queues received packets and hands them one at a time to
// the command dispatcher (IDLE -> ISSUE -> WAIT_DONE). Optional feature
// macro CMD_QUEUE_TIMEOUT_EN adds a WAIT_DONE watchdog driving tmo.
module cmd_pack_queue
    import cmd_pack_queue_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                   MAIN_CLK,
    input  logic                   MAIN_RST_N,
    input  logic                   link_ok,
    input  logic                   pk_valid,
    input  logic [CMD_W-1:0]       pk_cmd,
    input  logic [DATA_W-1:0]      pk_d1,
    input  logic [DATA_W-1:0]      pk_d2,
    output logic                   disp_start,
    output logic [CMD_W-1:0]       disp_cmd,
    output logic [DATA_W-1:0]      disp_d1,
    output logic [DATA_W-1:0]      disp_d2,
    input  logic                   disp_done,
    output logic [$clog2(DEPTH):0] q_level,
    output logic                   q_full,
    output logic                   ovf,
    output logic                   tmo,
    input  logic                   clr_err
);
    localparam int PK_W = CMD_W + 2*DATA_W;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH-1)) != 0) begin : g_bad_depth
        $error("cmd_pack_queue: DEPTH must be a power of 2 in 2..16");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("cmd_pack_queue: TIMEOUT must be at least 1");
    end

    disp_state_t       state_q, state_d;
    logic              pop, fifo_empty, ovf_set;
    logic [PK_W-1:0]   head;
    logic [CMD_W-1:0]  cmd_q;
    logic [DATA_W-1:0] d1_q, d2_q;
    logic              ovf_q;

    pack_fifo #(.DEPTH(DEPTH), .WIDTH(PK_W)) u_fifo (
        .clk   (MAIN_CLK),
        .rst_n (MAIN_RST_N),
        .flush (!link_ok),
        .push  (pk_valid),
        .pop   (pop),
        .wdata ({pk_cmd, pk_d1, pk_d2}),
        .rdata (head),
        .level (q_level),
        .full  (q_full),
        .empty (fifo_empty)
    );

    // Drops only count while the link is up; a flush cycle discards silently.
    assign ovf_set    = pk_valid && link_ok && q_full && !pop;
    assign disp_start = (state_q == ST_ISSUE);
    assign disp_cmd   = cmd_q;
    assign disp_d1    = d1_q;
    assign disp_d2    = d2_q;
    assign ovf        = ovf_q;

`ifdef CMD_QUEUE_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tcnt_q, tcnt_d;
    logic             tmo_q, tmo_set, tmo_hit;

    assign tmo_hit = (tcnt_q == TMO_W'(TIMEOUT - 1));
    assign tmo     = tmo_q;

    // Watchdog counts consecutive cycles spent in WAIT_DONE.
    always_comb tcnt_d = (state_q == ST_WAIT_DONE && state_d == ST_WAIT_DONE) ? tcnt_q + 1'b1 : '0;

    // Watchdog counter and sticky timeout flag (set beats clear).
    always_ff @(posedge MAIN_CLK or negedge MAIN_RST_N) begin
        if (!MAIN_RST_N) begin
            tcnt_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            tcnt_q <= tcnt_d;
            if (tmo_set)      tmo_q <= 1'b1;
            else if (clr_err) tmo_q <= 1'b0;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    // Dispatcher FSM next-state: pop in IDLE, one-cycle ISSUE, wait for done.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
`ifdef CMD_QUEUE_TIMEOUT_EN
        tmo_set = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (link_ok && !fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (disp_done) state_d = ST_IDLE;
`ifdef CMD_QUEUE_TIMEOUT_EN
                else if (tmo_hit) begin
                    state_d = ST_IDLE;
                    tmo_set = 1'b1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, issued-packet holding registers and sticky overflow flag.
    always_ff @(posedge MAIN_CLK or negedge MAIN_RST_N) begin
        if (!MAIN_RST_N) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            d1_q    <= '0;
            d2_q    <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (pop) {cmd_q, d1_q, d2_q} <= head;
            if (ovf_set)      ovf_q <= 1'b1;
            else if (clr_err) ovf_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cmd_pack_queue.sv
// Bench for cmd_pack_queue: directed table, hand-written corner sequences
// and randomized traffic against a transaction-level queue model.
module tb_cmd_pack_queue;
    localparam int DEPTH   = 4;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        link_ok, pk_valid, disp_done, clr_err;
    logic [7:0]  pk_cmd;
    logic [15:0] pk_d1, pk_d2;
    logic        disp_start;
    logic [7:0]  disp_cmd;
    logic [15:0] disp_d1, disp_d2;
    logic [2:0]  q_level;
    logic        q_full, ovf, tmo;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    cmd_pack_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .MAIN_CLK   (clk),
        .MAIN_RST_N (rst_n),
        .link_ok    (link_ok),
        .pk_valid   (pk_valid),
        .pk_cmd     (pk_cmd),
        .pk_d1      (pk_d1),
        .pk_d2      (pk_d2),
        .disp_start (disp_start),
        .disp_cmd   (disp_cmd),
        .disp_d1    (disp_d1),
        .disp_d2    (disp_d2),
        .disp_done  (disp_done),
        .q_level    (q_level),
        .q_full     (q_full),
        .ovf        (ovf),
        .tmo        (tmo),
        .clr_err    (clr_err)
    );

    typedef struct {
        logic       v;
        logic [7:0] cmd;
        logic       lk, dn, cl;
        int         lvl;
        logic       st, fl, ov;
        logic [7:0] ecmd;
    } vec_t;

    vec_t tbl[$];

    // reference model state
    logic [39:0] mq[$];
    int          m_phase;   // 0 no command, 1 issue pending visible, 2 awaiting done
    int          m_wait;
    logic [39:0] m_held;
    logic        m_ovf, m_tmo;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [15:0] pd1(input logic [7:0] c);
        return (c == 8'h11) ? 16'h1234 : {c, c};
    endfunction

    function automatic logic [15:0] pd2(input logic [7:0] c);
        return (c == 8'h11) ? 16'hABCD : ~{c, c};
    endfunction

    function automatic vec_t mk(input logic v, input logic [7:0] c, input logic lk, dn, cl,
                                input int lvl, input logic st, fl, ov, input logic [7:0] ec);
        vec_t r;
        r.v = v; r.cmd = c; r.lk = lk; r.dn = dn; r.cl = cl;
        r.lvl = lvl; r.st = st; r.fl = fl; r.ov = ov; r.ecmd = ec;
        return r;
    endfunction

    task automatic idle_inputs();
        link_ok = 1'b1; pk_valid = 1'b0; disp_done = 1'b0; clr_err = 1'b0;
        pk_cmd = '0; pk_d1 = '0; pk_d2 = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        m_phase = 0; m_wait = 0; m_held = '0; m_ovf = 1'b0; m_tmo = 1'b0;
    endtask

    task automatic model_step(input logic v, lk, dn, cl, input logic [39:0] pk);
        logic ovf_set;
        logic tmo_set;
        ovf_set = 1'b0;
        tmo_set = 1'b0;
        if (m_phase == 1) begin
            m_phase = 2;
            m_wait  = 0;
        end else if (m_phase == 2) begin
            if (dn) m_phase = 0;
`ifdef CMD_QUEUE_TIMEOUT_EN
            else if (m_wait == TIMEOUT - 1) begin
                m_phase = 0;
                tmo_set = 1'b1;
            end else m_wait++;
`endif
        end else if (lk && mq.size() > 0) begin
            m_held  = mq.pop_front();
            m_phase = 1;
        end
        if (!lk) mq.delete();
        else if (v) begin
            if (mq.size() < DEPTH) mq.push_back(pk);
            else ovf_set = 1'b1;
        end
        if (ovf_set) m_ovf = 1'b1; else if (cl) m_ovf = 1'b0;
        if (tmo_set) m_tmo = 1'b1; else if (cl) m_tmo = 1'b0;
    endtask

    initial begin
        logic [39:0] pk;
        logic        saw;
        int          s;

        // Directed table: single push latency, fill/overflow, push+pop at full,
        // link flush, clear-vs-set priority.
        tbl.push_back(mk(1, 8'h11, 1, 0, 0, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 8'h11));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h21, 1, 0, 0, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h22, 1, 0, 0, 2, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h23, 1, 0, 0, 3, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h24, 1, 0, 0, 4, 0, 1, 0, 8'h00));
        tbl.push_back(mk(1, 8'h25, 1, 0, 0, 4, 0, 1, 1, 8'h00));
        tbl.push_back(mk(1, 8'h26, 1, 0, 0, 4, 0, 1, 1, 8'h00));
        tbl.push_back(mk(0, 8'h00, 1, 1, 1, 4, 0, 1, 0, 8'h00));
        tbl.push_back(mk(1, 8'h27, 1, 0, 0, 4, 1, 1, 0, 8'h21));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 4, 0, 1, 0, 8'h00));
        tbl.push_back(mk(0, 8'h00, 1, 1, 0, 4, 0, 1, 0, 8'h00));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 3, 1, 0, 0, 8'h22));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 3, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h28, 0, 0, 0, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 8'h00, 1, 1, 0, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h29, 1, 0, 0, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 8'h29));
        tbl.push_back(mk(1, 8'h2A, 1, 0, 0, 1, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h2B, 1, 0, 0, 2, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h2C, 1, 0, 0, 3, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 8'h2D, 1, 0, 0, 4, 0, 1, 0, 8'h00));
        tbl.push_back(mk(1, 8'h2E, 1, 0, 1, 4, 0, 1, 1, 8'h00));
        tbl.push_back(mk(0, 8'h00, 1, 0, 1, 4, 0, 1, 0, 8'h00));
        tbl.push_back(mk(0, 8'h00, 1, 1, 0, 4, 0, 1, 0, 8'h00));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 3, 1, 0, 0, 8'h2A));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 3, 0, 0, 0, 8'h00));

        do_reset();
        #1;
        chk("reset_level", 64'(q_level), 64'd0);
        chk("reset_full",  64'(q_full), 64'd0);
        chk("reset_ovf",   64'(ovf), 64'd0);
        chk("reset_tmo",   64'(tmo), 64'd0);
        chk("reset_start", 64'(disp_start), 64'd0);
        chk("reset_disp",  64'({disp_cmd, disp_d1, disp_d2}), 64'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            idle_inputs();
            pk_valid = tbl[i].v;  pk_cmd = tbl[i].cmd;
            pk_d1 = pd1(tbl[i].cmd); pk_d2 = pd2(tbl[i].cmd);
            link_ok = tbl[i].lk; disp_done = tbl[i].dn; clr_err = tbl[i].cl;
            step();
            chk($sformatf("tbl%0d_level", i), 64'(q_level), 64'(tbl[i].lvl));
            chk($sformatf("tbl%0d_start", i), 64'(disp_start), 64'(tbl[i].st));
            chk($sformatf("tbl%0d_full", i),  64'(q_full), 64'(tbl[i].fl));
            chk($sformatf("tbl%0d_ovf", i),   64'(ovf), 64'(tbl[i].ov));
            if (tbl[i].st)
                chk($sformatf("tbl%0d_disp", i), 64'({disp_cmd, disp_d1, disp_d2}),
                    64'({tbl[i].ecmd, pd1(tbl[i].ecmd), pd2(tbl[i].ecmd)}));
        end

        // Reset asserted while waiting for done: immediate reset values,
        // late done must not trigger an issue.
        do_reset();
        idle_inputs();
        pk_valid = 1'b1; pk_cmd = 8'h31; pk_d1 = pd1(8'h31); pk_d2 = pd2(8'h31);
        step();
        pk_valid = 1'b1; pk_cmd = 8'h32; pk_d1 = pd1(8'h32); pk_d2 = pd2(8'h32);
        step();
        idle_inputs();
        step();
        step();
        chk("mid_wait_level", 64'(q_level), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_level", 64'(q_level), 64'd0);
        chk("async_rst_disp", 64'({disp_cmd, disp_d1, disp_d2}), 64'd0);
        chk("async_rst_start", 64'(disp_start), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        disp_done = 1'b1;
        step();
        disp_done = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (disp_start) saw = 1'b1;
        end
        chk("late_done_no_start", 64'(saw), 64'd0);

`ifdef CMD_QUEUE_TIMEOUT_EN
        // Watchdog: no done for TIMEOUT cycles in WAIT_DONE.
        do_reset();
        pk_valid = 1'b1; pk_cmd = 8'h41; pk_d1 = pd1(8'h41); pk_d2 = pd2(8'h41);
        step();
        pk_valid = 1'b1; pk_cmd = 8'h42; pk_d1 = pd1(8'h42); pk_d2 = pd2(8'h42);
        step();
        idle_inputs();
        s = 0;
        while (!disp_start && s < 10) begin step(); s++; end
        chk("tmo_first_start", 64'(disp_start), 64'd1);
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        step();
        chk("tmo_not_early", 64'(tmo), 64'd0);
        step();
        chk("tmo_set", 64'(tmo), 64'd1);
        step();
        chk("tmo_next_issue", 64'({disp_start, disp_cmd}), 64'({1'b1, 8'h42}));
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("tmo_cleared", 64'(tmo), 64'd0);
`endif

        // Randomized traffic against the queue model.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            idle_inputs();
            pk_valid  = ($urandom_range(99) < 45);
            pk_cmd    = 8'($urandom);
            pk_d1     = 16'($urandom);
            pk_d2     = 16'($urandom);
            link_ok   = ($urandom_range(99) >= 3);
            disp_done = ($urandom_range(99) < 25);
            clr_err   = ($urandom_range(99) < 8);
            pk = {pk_cmd, pk_d1, pk_d2};
            model_step(pk_valid, link_ok, disp_done, clr_err, pk);
            step();
            chk("rnd_level", 64'(q_level), 64'(mq.size()));
            chk("rnd_full",  64'(q_full), 64'(mq.size() == DEPTH));
            chk("rnd_ovf",   64'(ovf), 64'(m_ovf));
            chk("rnd_tmo",   64'(tmo), 64'(m_tmo));
            chk("rnd_start", 64'(disp_start), 64'(m_phase == 1));
            chk("rnd_disp",  64'({disp_cmd, disp_d1, disp_d2}), 64'(m_held));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
